// File: rtl/instruction_memory_p.sv
// ============================================================================
// Module   : instruction_memory_p
// Brief    : Parametrised instruction memory with a registered fetch port and
//            a sequential program-load port (RUN/LOAD modes). Optional word
//            parity is enabled by defining the macro PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_memory_p #(
    parameter int                 DATA_W = 8,
    parameter int                 ADDR_W = 4,
    parameter logic [DATA_W-1:0]  NOP    = {DATA_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_en,
    input  logic [ADDR_W-1:0] A,
    output logic [DATA_W-1:0] B,
    output logic              B_valid,
    input  logic              ld_start,
    input  logic              ld_valid,
    input  logic              ld_last,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic              ld_done,
`ifdef PARITY_EN
    input  logic              ld_bad_par,
`endif
    output logic              parity_err
);

    localparam int          c_DEPTH   = 2**ADDR_W;
    localparam logic [0:0]  c_ST_RUN  = 1'b0;
    localparam logic [0:0]  c_ST_LOAD = 1'b1;

`ifdef PARITY_EN
    localparam int          c_WORD_W  = DATA_W + 1;
`else
    localparam int          c_WORD_W  = DATA_W;
`endif

    logic [c_WORD_W-1:0] r_mem [c_DEPTH];
    logic [0:0]          r_state;
    logic [ADDR_W-1:0]   r_wptr;
    logic [DATA_W-1:0]   r_b;
    logic                r_b_valid;
    logic                r_ld_done;
    logic                r_parity_err;

    logic                w_wr;
    logic                w_wr_final;
    logic [c_WORD_W-1:0] w_wr_word;
    logic [c_WORD_W-1:0] w_rd_word;

    // ld_start wins over ld_valid, so a restart cycle never stores a word
    assign w_wr       = (r_state == c_ST_LOAD) && !ld_start && ld_valid;
    assign w_wr_final = ld_last || (r_wptr == ADDR_W'(c_DEPTH - 1));
    assign w_rd_word  = r_mem[A];

`ifdef PARITY_EN
    assign w_wr_word  = {(^ld_data) ^ ld_bad_par, ld_data};
`else
    assign w_wr_word  = ld_data;
`endif

    // Storage is intentionally not reset so a program survives rst
    always_ff @(posedge clk) begin
        if (!rst && w_wr) begin
            r_mem[r_wptr] <= w_wr_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_ST_RUN;
            r_wptr       <= '0;
            r_b          <= NOP;
            r_b_valid    <= 1'b0;
            r_ld_done    <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            r_b          <= NOP;
            r_b_valid    <= 1'b0;
            r_ld_done    <= 1'b0;
            r_parity_err <= 1'b0;
            case (r_state)
                c_ST_RUN: begin
                    if (ld_start) begin
                        r_state <= c_ST_LOAD;
                        r_wptr  <= '0;
                    end else if (fetch_en) begin
                        r_b       <= w_rd_word[DATA_W-1:0];
                        r_b_valid <= 1'b1;
`ifdef PARITY_EN
                        r_parity_err <= (^w_rd_word[DATA_W-1:0]) != w_rd_word[DATA_W];
`endif
                    end
                end
                c_ST_LOAD: begin
                    if (ld_start) begin
                        r_wptr <= '0;
                    end else if (ld_valid) begin
                        if (w_wr_final) begin
                            r_state   <= c_ST_RUN;
                            r_wptr    <= '0;
                            r_ld_done <= 1'b1;
                        end else begin
                            r_wptr <= r_wptr + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= c_ST_RUN;
                    r_wptr  <= '0;
                end
            endcase
        end
    end

    assign B          = r_b;
    assign B_valid    = r_b_valid;
    assign ld_ready   = (r_state == c_ST_LOAD);
    assign ld_done    = r_ld_done;
    assign parity_err = r_parity_err;

endmodule

`default_nettype wire
